// File: rtl/uart_receiver.sv
// UART receive path: 2-flop synchronizer, start/data/parity/stop FSM driven by an
// external oversampling tick, and a valid/ready output stage with sticky overrun.
`timescale 1ns/1ps
module uart_receiver #(
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic       sample_tick,
    input  logic       rx,
    input  logic       parity_en,
    input  logic       parity_odd,
    input  logic       rx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int unsigned TW = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] MID_START = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] MID_BIT   = TW'(OVERSAMPLE - 1);
    localparam logic [TW-1:0] TICK_ONE  = TW'(1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t        state, state_n;
    logic [TW-1:0] tick_cnt, tick_n;
    logic [2:0]    bit_cnt, bit_n;
    logic [7:0]    shreg, shreg_n;
    logic          pen_q, pen_n;
    logic          podd_q, podd_n;
    logic          perr_q, perr_n;
    logic          ferr_n;
    logic          deliver;
    logic          accept;

    logic rx_meta, rx_s, rx_s_prev;

    // Synchronizer and edge-detect history idle high so reset never looks like a start edge
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            rx_meta   <= 1'b1;
            rx_s      <= 1'b1;
            rx_s_prev <= 1'b1;
        end else begin
            rx_meta   <= rx;
            rx_s      <= rx_meta;
            rx_s_prev <= rx_s;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state    <= IDLE;
            tick_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            pen_q    <= 1'b0;
            podd_q   <= 1'b0;
            perr_q   <= 1'b0;
        end else begin
            state    <= state_n;
            tick_cnt <= tick_n;
            bit_cnt  <= bit_n;
            shreg    <= shreg_n;
            pen_q    <= pen_n;
            podd_q   <= podd_n;
            perr_q   <= perr_n;
        end
    end

    always_comb begin
        state_n = state;
        tick_n  = tick_cnt;
        bit_n   = bit_cnt;
        shreg_n = shreg;
        pen_n   = pen_q;
        podd_n  = podd_q;
        perr_n  = perr_q;
        ferr_n  = 1'b0;
        deliver = 1'b0;
        unique case (state)
            IDLE: begin
                if (rx_s_prev && !rx_s) begin
                    state_n = START;
                    tick_n  = '0;
                    pen_n   = parity_en;
                    podd_n  = parity_odd;
                    perr_n  = 1'b0;
                end
            end
            START: begin
                if (sample_tick) begin
                    if (tick_cnt == MID_START) begin
                        if (!rx_s) begin
                            state_n = DATA;
                            tick_n  = '0;
                            bit_n   = '0;
                        end else begin
                            state_n = IDLE;
                        end
                    end else begin
                        tick_n = tick_cnt + TICK_ONE;
                    end
                end
            end
            DATA: begin
                if (sample_tick) begin
                    if (tick_cnt == MID_BIT) begin
                        shreg_n = {rx_s, shreg[7:1]};
                        tick_n  = '0;
                        bit_n   = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            state_n = pen_q ? PARITY : STOP;
                        end
                    end else begin
                        tick_n = tick_cnt + TICK_ONE;
                    end
                end
            end
            PARITY: begin
                if (sample_tick) begin
                    if (tick_cnt == MID_BIT) begin
                        // expected bit is ^shreg, inverted for odd parity
                        perr_n  = rx_s ^ (^shreg) ^ podd_q;
                        tick_n  = '0;
                        state_n = STOP;
                    end else begin
                        tick_n = tick_cnt + TICK_ONE;
                    end
                end
            end
            STOP: begin
                if (sample_tick) begin
                    if (tick_cnt == MID_BIT) begin
                        ferr_n  = ~rx_s;
                        deliver = 1'b1;
                        tick_n  = '0;
                        state_n = IDLE;
                    end else begin
                        tick_n = tick_cnt + TICK_ONE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign accept = rx_valid & rx_ready;
    assign busy   = (state != IDLE);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else if (deliver && (!rx_valid || rx_ready)) begin
            rx_data    <= shreg;
            parity_err <= perr_q;
            frame_err  <= ferr_n;
            rx_valid   <= 1'b1;
            // An accept in the same cycle consumes the old byte and its overrun
            if (accept) begin
                overrun <= 1'b0;
            end
        end else if (deliver) begin
            overrun <= 1'b1;
        end else if (accept) begin
            rx_valid <= 1'b0;
            overrun  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver: table of frames plus hand-written sequences for
// false start, break, overrun, simultaneous accept/deliver and mid-frame reset.
`timescale 1ns/1ps
module tb_uart_receiver;

    logic       clk;
    logic       nrst;
    logic       sample_tick;
    logic       rx;
    logic       parity_en;
    logic       parity_odd;
    logic       rx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       parity_err;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    uart_receiver #(.OVERSAMPLE(16)) dut (
        .clk        (clk),
        .nrst       (nrst),
        .sample_tick(sample_tick),
        .rx         (rx),
        .parity_en  (parity_en),
        .parity_odd (parity_odd),
        .rx_ready   (rx_ready),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int         cyc = 0;
    int         start_cyc = 0;
    int         lat = 0;
    int         vcyc = 0;
    int         busy_cnt = 0;
    logic       valid_prev = 1'b0;
    logic [7:0] cap_data = '0;
    logic       cap_perr = 1'b0;
    logic       cap_ferr = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rx_valid) begin
            vcyc     <= vcyc + 1;
            cap_data <= rx_data;
            cap_perr <= parity_err;
            cap_ferr <= frame_err;
        end
        if (rx_valid && !valid_prev) lat <= cyc - start_cyc;
        valid_prev <= rx_valid;
        if (busy) busy_cnt <= busy_cnt + 1;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic settle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Each bit is held exactly 16 clk; the line is left at the stop-bit level
    task automatic send(input logic [7:0] d, input logic pen, input logic pbit, input logic stop);
        @(posedge clk);
        #1;
        rx = 1'b0;
        start_cyc = cyc;
        repeat (16) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            #1;
            rx = d[i];
            repeat (16) @(posedge clk);
        end
        if (pen) begin
            #1;
            rx = pbit;
            repeat (16) @(posedge clk);
        end
        #1;
        rx = stop;
        repeat (16) @(posedge clk);
    endtask

    typedef struct {
        logic [7:0] data;
        logic       pen;
        logic       podd;
        logic       pbit;
        logic [7:0] exp_data;
        logic       exp_perr;
    } vec_t;

    localparam int NV = 8;
    vec_t vecs[NV];

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    initial begin
        int v0;
        int b0;

        vecs[0] = '{8'hA5, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b0};
        vecs[1] = '{8'h3C, 1'b1, 1'b0, 1'b1, 8'h3C, 1'b1};
        vecs[2] = '{8'h3C, 1'b1, 1'b0, 1'b0, 8'h3C, 1'b0};
        vecs[3] = '{8'h3C, 1'b1, 1'b1, 1'b1, 8'h3C, 1'b0};
        vecs[4] = '{8'h3C, 1'b1, 1'b1, 1'b0, 8'h3C, 1'b1};
        vecs[5] = '{8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0};
        vecs[6] = '{8'hFF, 1'b0, 1'b1, 1'b0, 8'hFF, 1'b0};
        vecs[7] = '{8'h5A, 1'b1, 1'b1, 1'b1, 8'h5A, 1'b0};

        nrst = 1'b0;
        sample_tick = 1'b1;
        rx = 1'b1;
        rx_ready = 1'b1;
        parity_en = 1'b0;
        parity_odd = 1'b0;
        settle(3);
        chk("reset_rx_data", rx_data, 0);
        chk("reset_rx_valid", rx_valid, 0);
        chk("reset_parity_err", parity_err, 0);
        chk("reset_frame_err", frame_err, 0);
        chk("reset_overrun", overrun, 0);
        chk("reset_busy", busy, 0);
        nrst = 1'b1;
        settle(3);

        for (int i = 0; i < NV; i++) begin
            parity_en = vecs[i].pen;
            parity_odd = vecs[i].podd;
            v0 = vcyc;
            send(vecs[i].data, vecs[i].pen, vecs[i].pbit, 1'b1);
            settle(4);
            chk($sformatf("vec%0d_valid_cycles", i), vcyc - v0, 1);
            chk($sformatf("vec%0d_data", i), cap_data, vecs[i].exp_data);
            chk($sformatf("vec%0d_parity_err", i), cap_perr, vecs[i].exp_perr);
            chk($sformatf("vec%0d_frame_err", i), cap_ferr, 0);
            chk($sformatf("vec%0d_latency", i), lat, vecs[i].pen ? 171 : 155);
            chk($sformatf("vec%0d_busy_after", i), busy, 0);
        end
        parity_en = 1'b0;
        parity_odd = 1'b0;

        // False start: 4 clk low pulse rejected at the mid-start check
        v0 = vcyc;
        b0 = busy_cnt;
        @(posedge clk);
        #1;
        rx = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rx = 1'b1;
        settle(30);
        chk("glitch_busy_cycles", busy_cnt - b0, 8);
        chk("glitch_no_valid", vcyc - v0, 0);
        chk("glitch_busy_after", busy, 0);

        // Parity settings are latched at the start edge
        parity_en = 1'b1;
        parity_odd = 1'b0;
        fork
            send(8'h3C, 1'b1, 1'b1, 1'b1);
            begin
                settle(48);
                parity_en = 1'b0;
                parity_odd = 1'b1;
            end
        join
        settle(4);
        chk("latch_data", cap_data, 8'h3C);
        chk("latch_parity_err", cap_perr, 1);
        chk("latch_latency", lat, 171);
        parity_en = 1'b0;
        parity_odd = 1'b0;

        // Frame error followed by a held-low line
        v0 = vcyc;
        send(8'h81, 1'b0, 1'b0, 1'b0);
        settle(200);
        chk("break_valid_cycles", vcyc - v0, 1);
        chk("break_data", cap_data, 8'h81);
        chk("break_frame_err", cap_ferr, 1);
        chk("break_parity_err", cap_perr, 0);
        chk("break_busy", busy, 0);
        rx = 1'b1;
        settle(20);
        send(8'h42, 1'b0, 1'b0, 1'b1);
        settle(4);
        chk("after_break_valid_cycles", vcyc - v0, 2);
        chk("after_break_data", cap_data, 8'h42);
        chk("after_break_frame_err", cap_ferr, 0);

        // Overrun with consumer stalled
        rx_ready = 1'b0;
        send(8'h11, 1'b0, 1'b0, 1'b1);
        settle(5);
        send(8'h22, 1'b0, 1'b0, 1'b1);
        settle(5);
        chk("ovr_valid", rx_valid, 1);
        chk("ovr_data", rx_data, 8'h11);
        chk("ovr_flag", overrun, 1);
        rx_ready = 1'b1;
        settle(1);
        rx_ready = 1'b0;
        chk("ovr_accept_valid", rx_valid, 0);
        chk("ovr_accept_flag", overrun, 0);
        send(8'h33, 1'b0, 1'b0, 1'b1);
        settle(4);
        chk("post_ovr_valid", rx_valid, 1);
        chk("post_ovr_data", rx_data, 8'h33);
        chk("post_ovr_flag", overrun, 0);

        // Accept lands on the exact delivery edge (155 clk after the start bit)
        fork
            send(8'h44, 1'b0, 1'b0, 1'b1);
            begin
                @(posedge clk);
                repeat (154) @(posedge clk);
                #1;
                rx_ready = 1'b1;
                @(posedge clk);
                #1;
                rx_ready = 1'b0;
            end
        join
        settle(4);
        chk("simul_valid", rx_valid, 1);
        chk("simul_data", rx_data, 8'h44);
        chk("simul_overrun", overrun, 0);

        // Reset during data bit 4 with a byte still pending
        fork
            send(8'h96, 1'b0, 1'b0, 1'b1);
            begin
                @(posedge clk);
                repeat (88) @(posedge clk);
                #1;
                nrst = 1'b0;
                #1;
                chk("midrst_rx_data", rx_data, 0);
                chk("midrst_rx_valid", rx_valid, 0);
                chk("midrst_parity_err", parity_err, 0);
                chk("midrst_frame_err", frame_err, 0);
                chk("midrst_overrun", overrun, 0);
                chk("midrst_busy", busy, 0);
            end
        join
        settle(5);
        nrst = 1'b1;
        settle(5);
        chk("postrst_busy", busy, 0);
        chk("postrst_valid", rx_valid, 0);
        rx_ready = 1'b1;
        v0 = vcyc;
        send(8'h5A, 1'b0, 1'b0, 1'b1);
        settle(4);
        chk("postrst_valid_cycles", vcyc - v0, 1);
        chk("postrst_data", cap_data, 8'h5A);
        chk("postrst_parity_err", cap_perr, 0);
        chk("postrst_frame_err", cap_ferr, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
